// File: rtl/sm_ctrl_pkg.sv
// Shared definitions for the serial matmul controller: FSM states, command
// opcodes, fixed register map and adder input-select codes.
package sm_ctrl_pkg;

   typedef enum logic [4:0] {
      ST_IDLE,
      ST_CHK,
      ST_CMP,
      ST_REQA,
      ST_WTA,
      ST_REQB,
      ST_WTB,
      ST_MLD,
      ST_MUL,
      ST_ALD,
      ST_ACC,
      ST_PALD,
      ST_PA,
      ST_PBLD,
      ST_PB,
      ST_JLD,
      ST_J,
      ST_RLD,
      ST_RELU,
      ST_RESP
   } sm_state_t;

   localparam logic [6:0] SM_FUNCT_DOT       = 7'h40;
   localparam logic [6:0] SM_FUNCT_LOAD_MASK = 7'h40;

   // Register map used by the DOT sequence.
   localparam int SM_R0 = 0;  // A pointer
   localparam int SM_R1 = 1;  // B pointer
   localparam int SM_R2 = 2;  // {N, M}
   localparam int SM_R3 = 3;  // j
   localparam int SM_R4 = 4;  // accumulator
   localparam int SM_R5 = 5;  // a temp
   localparam int SM_R6 = 6;  // b temp
   localparam int SM_R7 = 7;  // product

   localparam logic [1:0] SM_ADD_A     = 2'd0;
   localparam logic [1:0] SM_ADD_ONE   = 2'd1;
   localparam logic [1:0] SM_ADD_TWO   = 2'd2;
   localparam logic [1:0] SM_ADD_EIGHT = 2'd3;

   function automatic logic sm_is_load_r(input logic [6:0] funct);
      return (funct & SM_FUNCT_LOAD_MASK) == 7'h00;
   endfunction

endpackage

// File: rtl/serial_matmul_ctrl.sv
// Control FSM for the serial matmul datapath: decodes processor commands,
// sequences the shared write bus and runs the memory-fed ReLU dot product.
module serial_matmul_ctrl
   import sm_ctrl_pkg::*;
#(
   parameter int R_ADDR = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   // All ports use valid/ready: a transfer happens in a cycle where both are
   // high; the source holds valid and its payload steady until that cycle.
   input  logic              cmd_val,
   output logic              cmd_rdy,
   input  logic [6:0]        cmd_inst_funct,
   input  logic [4:0]        cmd_inst_rd,
   output logic              mem_req_val,
   input  logic              mem_req_rdy,
   output logic              mem_req_rw,
   input  logic              mem_resp_val,
   output logic              mem_resp_rdy,
   output logic              resp_val,
   input  logic              resp_rdy,
   output logic [4:0]        resp_rd,
   output logic              src_bus_en,
   output logic              resp_bus_en,
   output logic              add_bus_en,
   output logic              mul_bus_en,
   output logic              relu_bus_en,
   output logic              sws_bus_en,
   output logic              r_wen,
   output logic [R_ADDR-1:0] r_waddr,
   output logic [R_ADDR-1:0] r_raddr0,
   output logic [R_ADDR-1:0] r_raddr1,
   output logic              a_en,
   output logic              b_en,
   output logic [1:0]        add_sel,
   output logic              comp_sel,
   input  logic              a_eq_b,
   output logic              busy,
   output logic [4:0]        state_dbg
);

   localparam logic [R_ADDR-1:0] RA_APTR = R_ADDR'(SM_R0);
   localparam logic [R_ADDR-1:0] RA_BPTR = R_ADDR'(SM_R1);
   localparam logic [R_ADDR-1:0] RA_NM   = R_ADDR'(SM_R2);
   localparam logic [R_ADDR-1:0] RA_J    = R_ADDR'(SM_R3);
   localparam logic [R_ADDR-1:0] RA_ACC  = R_ADDR'(SM_R4);
   localparam logic [R_ADDR-1:0] RA_ATMP = R_ADDR'(SM_R5);
   localparam logic [R_ADDR-1:0] RA_BTMP = R_ADDR'(SM_R6);
   localparam logic [R_ADDR-1:0] RA_PROD = R_ADDR'(SM_R7);

   sm_state_t state;
   sm_state_t state_next;
   logic      dot_accept;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         resp_rd <= '0;
      end else begin
         state <= state_next;
         if (dot_accept) begin
            resp_rd <= cmd_inst_rd;
         end
      end
   end

   assign mem_req_rw = 1'b0;
   assign sws_bus_en = 1'b0;
   assign comp_sel   = 1'b0;
   assign busy       = (state != ST_IDLE);
   assign state_dbg  = state;

   always_comb begin
      state_next   = state;
      dot_accept   = 1'b0;
      cmd_rdy      = 1'b0;
      mem_req_val  = 1'b0;
      mem_resp_rdy = 1'b0;
      resp_val     = 1'b0;
      src_bus_en   = 1'b0;
      resp_bus_en  = 1'b0;
      add_bus_en   = 1'b0;
      mul_bus_en   = 1'b0;
      relu_bus_en  = 1'b0;
      r_wen        = 1'b0;
      r_waddr      = '0;
      r_raddr0     = '0;
      r_raddr1     = '0;
      a_en         = 1'b0;
      b_en         = 1'b0;
      add_sel      = SM_ADD_A;

      unique case (state)
         ST_IDLE: begin
            cmd_rdy = 1'b1;
            // LOAD_R writes straight from the command source in the accept
            // cycle; unknown opcodes with funct[6] set are simply consumed.
            if (cmd_val) begin
               if (sm_is_load_r(cmd_inst_funct)) begin
                  src_bus_en = 1'b1;
                  r_wen      = 1'b1;
                  r_waddr    = R_ADDR'(cmd_inst_funct[3:0]);
               end else if (cmd_inst_funct == SM_FUNCT_DOT) begin
                  dot_accept = 1'b1;
                  state_next = ST_CHK;
               end
            end
         end

         ST_CHK: begin
            r_raddr0   = RA_NM;
            r_raddr1   = RA_J;
            a_en       = 1'b1;
            b_en       = 1'b1;
            state_next = ST_CMP;
         end

         ST_CMP: begin
            state_next = a_eq_b ? ST_RLD : ST_REQA;
         end

         ST_REQA: begin
            mem_req_val = 1'b1;
            r_raddr0    = RA_APTR;
            if (mem_req_rdy) begin
               state_next = ST_WTA;
            end
         end

         ST_WTA: begin
            mem_resp_rdy = 1'b1;
            if (mem_resp_val) begin
               resp_bus_en = 1'b1;
               r_wen       = 1'b1;
               r_waddr     = RA_ATMP;
               state_next  = ST_REQB;
            end
         end

         ST_REQB: begin
            mem_req_val = 1'b1;
            r_raddr0    = RA_BPTR;
            if (mem_req_rdy) begin
               state_next = ST_WTB;
            end
         end

         ST_WTB: begin
            mem_resp_rdy = 1'b1;
            if (mem_resp_val) begin
               resp_bus_en = 1'b1;
               r_wen       = 1'b1;
               r_waddr     = RA_BTMP;
               state_next  = ST_MLD;
            end
         end

         ST_MLD: begin
            r_raddr0   = RA_ATMP;
            r_raddr1   = RA_BTMP;
            a_en       = 1'b1;
            b_en       = 1'b1;
            state_next = ST_MUL;
         end

         ST_MUL: begin
            mul_bus_en = 1'b1;
            r_wen      = 1'b1;
            r_waddr    = RA_PROD;
            state_next = ST_ALD;
         end

         ST_ALD: begin
            r_raddr0   = RA_ACC;
            r_raddr1   = RA_PROD;
            a_en       = 1'b1;
            b_en       = 1'b1;
            state_next = ST_ACC;
         end

         ST_ACC: begin
            add_sel    = SM_ADD_A;
            add_bus_en = 1'b1;
            r_wen      = 1'b1;
            r_waddr    = RA_ACC;
            state_next = ST_PALD;
         end

         // Pointer and index bumps only load B; the adder's other input is
         // a constant selected by add_sel.
         ST_PALD: begin
            r_raddr1   = RA_APTR;
            b_en       = 1'b1;
            state_next = ST_PA;
         end

         ST_PA: begin
            add_sel    = SM_ADD_EIGHT;
            add_bus_en = 1'b1;
            r_wen      = 1'b1;
            r_waddr    = RA_APTR;
            state_next = ST_PBLD;
         end

         ST_PBLD: begin
            r_raddr1   = RA_BPTR;
            b_en       = 1'b1;
            state_next = ST_PB;
         end

         ST_PB: begin
            add_sel    = SM_ADD_EIGHT;
            add_bus_en = 1'b1;
            r_wen      = 1'b1;
            r_waddr    = RA_BPTR;
            state_next = ST_JLD;
         end

         ST_JLD: begin
            r_raddr1   = RA_J;
            b_en       = 1'b1;
            state_next = ST_J;
         end

         ST_J: begin
            add_sel    = SM_ADD_ONE;
            add_bus_en = 1'b1;
            r_wen      = 1'b1;
            r_waddr    = RA_J;
            state_next = ST_CHK;
         end

         ST_RLD: begin
            r_raddr1   = RA_ACC;
            b_en       = 1'b1;
            state_next = ST_RELU;
         end

         ST_RELU: begin
            relu_bus_en = 1'b1;
            r_wen       = 1'b1;
            r_waddr     = RA_ACC;
            state_next  = ST_RESP;
         end

         ST_RESP: begin
            resp_val = 1'b1;
            if (resp_rdy) begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_matmul_ctrl.sv
// Bench for serial_matmul_ctrl: a behavioural datapath and memory driven by
// the controller's strobes, with a scoreboard of expected DOT completions.
module tb_serial_matmul_ctrl;
   import sm_ctrl_pkg::*;

   localparam int R_ADDR = 4;
   localparam int EXP_W  = 69;  // {r4[31:0], rd[4:0], rise[15:0], done[15:0]}

   logic              clk;
   logic              reset_n;
   logic              cmd_val, cmd_rdy;
   logic [6:0]        cmd_inst_funct;
   logic [4:0]        cmd_inst_rd;
   logic              mem_req_val, mem_req_rdy, mem_req_rw;
   logic              mem_resp_val, mem_resp_rdy;
   logic              resp_val, resp_rdy;
   logic [4:0]        resp_rd;
   logic              src_bus_en, resp_bus_en, add_bus_en, mul_bus_en, relu_bus_en, sws_bus_en;
   logic              r_wen;
   logic [R_ADDR-1:0] r_waddr, r_raddr0, r_raddr1;
   logic              a_en, b_en;
   logic [1:0]        add_sel;
   logic              comp_sel;
   logic              a_eq_b;
   logic              busy;
   logic [4:0]        state_dbg;

   logic [31:0]       cmd_data;
   logic [31:0]       mem_resp_data;
   logic [27:0]       misc_out;

   serial_matmul_ctrl #(.R_ADDR(R_ADDR)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_val(cmd_val), .cmd_rdy(cmd_rdy),
      .cmd_inst_funct(cmd_inst_funct), .cmd_inst_rd(cmd_inst_rd),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_rw(mem_req_rw),
      .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
      .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_rd(resp_rd),
      .src_bus_en(src_bus_en), .resp_bus_en(resp_bus_en), .add_bus_en(add_bus_en),
      .mul_bus_en(mul_bus_en), .relu_bus_en(relu_bus_en), .sws_bus_en(sws_bus_en),
      .r_wen(r_wen), .r_waddr(r_waddr), .r_raddr0(r_raddr0), .r_raddr1(r_raddr1),
      .a_en(a_en), .b_en(b_en), .add_sel(add_sel), .comp_sel(comp_sel),
      .a_eq_b(a_eq_b), .busy(busy), .state_dbg(state_dbg)
   );

   assign misc_out = {mem_req_val, mem_req_rw, mem_resp_rdy, resp_val,
                      src_bus_en, resp_bus_en, add_bus_en, mul_bus_en, relu_bus_en, sws_bus_en,
                      r_wen, r_waddr, r_raddr0, r_raddr1, a_en, b_en, add_sel, comp_sel};

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cap=500000 required=finish");
      $fatal(1, "watchdog expired");
   end

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;
   int resp_count   = 0;

   // datapath / memory model state
   logic [31:0] rf [16];
   logic [31:0] a_reg, b_reg;
   logic [31:0] mem [128];
   logic [31:0] pend_data_q [$];
   int          pend_ready_q [$];

   // scoreboard
   logic [EXP_W-1:0] exp_q [$];
   logic [31:0]      exp_addr_q [$];

   int          req_block_left  = 0;
   int          resp_extra      = 0;
   int          resp_rdy_block  = 0;
   bit          hold_active     = 0;
   logic [3:0]  hold_raddr      = '0;
   int          acc_cyc         = 0;
   bit          resp_risen      = 0;
   int          rise_rel        = 0;

   function automatic logic [6:0] mem_idx(input logic [31:0] addr);
      return addr[9:3];
   endfunction

   // Samples the settled cycle, checks it and applies the datapath edge.
   task automatic monitor();
      logic [31:0]      bus, add_in0, addr, rd_a, rd_b;
      logic [EXP_W-1:0] e;
      int               nbus;
      if (!reset_n) begin
         pend_data_q.delete();
         pend_ready_q.delete();
         hold_active = 0;
         resp_risen  = 0;
         return;
      end
      nbus = int'(src_bus_en) + int'(resp_bus_en) + int'(add_bus_en) + int'(mul_bus_en)
           + int'(relu_bus_en) + int'(sws_bus_en);
      tests_run++;
      if (nbus != int'(r_wen) || sws_bus_en || mem_req_rw || comp_sel || (busy == cmd_rdy)
          || (mem_resp_rdy && !busy)) begin
         tests_failed++;
         $display("FAIL invariant cyc=%0d: nbus=%0d r_wen=%0b sws=%0b rw=%0b comp_sel=%0b busy=%0b cmd_rdy=%0b mem_resp_rdy=%0b",
                  cyc, nbus, r_wen, sws_bus_en, mem_req_rw, comp_sel, busy, cmd_rdy, mem_resp_rdy);
      end

      case (add_sel)
         2'd0:    add_in0 = a_reg;
         2'd1:    add_in0 = 32'd1;
         2'd2:    add_in0 = 32'd2;
         default: add_in0 = 32'd8;
      endcase
      bus = 32'h0;
      if (src_bus_en)  bus = cmd_data;
      if (resp_bus_en) bus = mem_resp_data;
      if (add_bus_en)  bus = add_in0 + b_reg;
      if (mul_bus_en)  bus = a_reg * b_reg;
      if (relu_bus_en) bus = b_reg[31] ? 32'h0 : b_reg;

      if (mem_req_val) begin
         if (hold_active) begin
            tests_run++;
            if (r_raddr0 !== hold_raddr) begin
               tests_failed++;
               $display("FAIL req_addr_hold cyc=%0d: raddr0=%0d required=%0d", cyc, r_raddr0, hold_raddr);
            end
         end
         if (mem_req_rdy) begin
            addr = rf[r_raddr0];
            tests_run++;
            if (exp_addr_q.size() == 0) begin
               tests_failed++;
               $display("FAIL mem_req_addr cyc=%0d: unexpected request to %h", cyc, addr);
            end else begin
               if (addr !== exp_addr_q[0]) begin
                  tests_failed++;
                  $display("FAIL mem_req_addr cyc=%0d: addr=%h required=%h", cyc, addr, exp_addr_q[0]);
               end
               void'(exp_addr_q.pop_front());
            end
            pend_data_q.push_back(mem[mem_idx(addr)]);
            pend_ready_q.push_back(cyc + 1 + resp_extra);
            resp_extra  = 0;
            hold_active = 0;
         end else if (!hold_active) begin
            hold_active = 1;
            hold_raddr  = r_raddr0;
         end
      end else if (hold_active) begin
         tests_run++;
         tests_failed++;
         $display("FAIL req_val_hold cyc=%0d: mem_req_val=0 required=1", cyc);
         hold_active = 0;
      end

      if (mem_resp_val && mem_resp_rdy && pend_data_q.size() > 0) begin
         void'(pend_data_q.pop_front());
         void'(pend_ready_q.pop_front());
      end

      if (cmd_val && cmd_rdy && cmd_inst_funct == 7'h40) begin
         acc_cyc    = cyc;
         resp_risen = 0;
      end
      if (resp_val && !resp_risen) begin
         resp_risen = 1;
         rise_rel   = cyc - acc_cyc;
      end
      if (resp_val && resp_rdy) begin
         resp_count++;
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL resp_unexpected cyc=%0d: resp_val=1 required=0", cyc);
         end else begin
            e = exp_q.pop_front();
            tests_run += 4;
            if (rf[4] !== e[68:37]) begin
               tests_failed++;
               $display("FAIL dot_r4: R4=%h required=%h", rf[4], e[68:37]);
            end
            if (resp_rd !== e[36:32]) begin
               tests_failed++;
               $display("FAIL resp_rd: resp_rd=%0d required=%0d", resp_rd, e[36:32]);
            end
            if (16'(rise_rel) !== e[31:16]) begin
               tests_failed++;
               $display("FAIL resp_rise_cycle: cycle=%0d required=%0d", rise_rel, e[31:16]);
            end
            if (16'(cyc - acc_cyc) !== e[15:0]) begin
               tests_failed++;
               $display("FAIL resp_done_cycle: cycle=%0d required=%0d", cyc - acc_cyc, e[15:0]);
            end
         end
      end

      rd_a = rf[r_raddr0];
      rd_b = rf[r_raddr1];
      if (r_wen) rf[r_waddr] = bus;
      if (a_en)  a_reg = rd_a;
      if (b_en)  b_reg = rd_b;
   endtask

   task automatic drive_responders();
      a_eq_b = (a_reg[31:16] == b_reg[15:0]);
      if (mem_req_val && req_block_left > 0) begin
         mem_req_rdy = 1'b0;
         req_block_left--;
      end else begin
         mem_req_rdy = 1'b1;
      end
      if (pend_data_q.size() > 0 && cyc >= pend_ready_q[0]) begin
         mem_resp_val  = 1'b1;
         mem_resp_data = pend_data_q[0];
      end else begin
         mem_resp_val  = 1'b0;
         mem_resp_data = 32'h0;
      end
      if (resp_val && resp_rdy_block > 0) begin
         resp_rdy = 1'b0;
         resp_rdy_block--;
      end else begin
         resp_rdy = 1'b1;
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic tick();
      #3;
      monitor();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      drive_responders();
   endtask

   // driver tasks
   task automatic load_r(input logic [3:0] idx, input logic [31:0] data);
      cmd_val        = 1'b1;
      cmd_inst_funct = {3'b000, idx};
      cmd_data       = data;
      #1;
      tests_run++;
      if ({src_bus_en, r_wen, r_waddr, resp_val} !== {1'b1, 1'b1, idx, 1'b0}) begin
         tests_failed++;
         $display("FAIL load_r_strobe: src=%0b wen=%0b waddr=%0d resp_val=%0b required src=1 wen=1 waddr=%0d resp_val=0",
                  src_bus_en, r_wen, r_waddr, resp_val, idx);
      end
      tick();
      cmd_val = 1'b0;
   endtask

   task automatic start_dot(input logic [4:0] rd);
      cmd_val        = 1'b1;
      cmd_inst_funct = SM_FUNCT_DOT;
      cmd_inst_rd    = rd;
      #1;
      tests_run++;
      if (cmd_rdy !== 1'b1 || r_wen !== 1'b0) begin
         tests_failed++;
         $display("FAIL dot_accept: cmd_rdy=%0b r_wen=%0b required cmd_rdy=1 r_wen=0", cmd_rdy, r_wen);
      end
      tick();
      cmd_val     = 1'b0;
      cmd_inst_rd = 5'd0;
   endtask

   task automatic wait_resp(input int budget);
      int start;
      int k;
      start = resp_count;
      k = 0;
      while (resp_count == start && k < budget) begin
         tick();
         k++;
      end
      tests_run++;
      if (resp_count == start) begin
         tests_failed++;
         $display("FAIL dot_timeout: no response after %0d cycles, required one", budget);
      end
   endtask

   task automatic run_dot(input int n, input logic [31:0] abase, input logic [31:0] bbase,
                          input logic [31:0] r4_init, input logic [4:0] rd,
                          input int extra_rise, input int extra_done);
      logic [31:0] acc;
      acc = r4_init;
      for (int i = 0; i < n; i++) begin
         acc = acc + mem[mem_idx(abase + 32'(8 * i))] * mem[mem_idx(bbase + 32'(8 * i))];
         exp_addr_q.push_back(abase + 32'(8 * i));
         exp_addr_q.push_back(bbase + 32'(8 * i));
      end
      if (acc[31]) acc = 32'h0;
      exp_q.push_back({acc, rd, 16'(16 * n + 5 + extra_rise), 16'(16 * n + 5 + extra_done)});
      load_r(4'd0, abase);
      load_r(4'd1, bbase);
      load_r(4'd2, {16'(n), 16'h0});
      load_r(4'd3, 32'h0);
      load_r(4'd4, r4_init);
      start_dot(rd);
      wait_resp(1000);
      #1;
      tests_run += 3;
      if (rf[0] !== abase + 32'(8 * n) || rf[1] !== bbase + 32'(8 * n)) begin
         tests_failed++;
         $display("FAIL dot_ptrs: R0=%h R1=%h required R0=%h R1=%h",
                  rf[0], rf[1], abase + 32'(8 * n), bbase + 32'(8 * n));
      end
      if (rf[3] !== 32'(n)) begin
         tests_failed++;
         $display("FAIL dot_j: R3=%0d required=%0d", rf[3], n);
      end
      if (cmd_rdy !== 1'b1 || busy !== 1'b0 || exp_addr_q.size() != 0) begin
         tests_failed++;
         $display("FAIL dot_end_idle: cmd_rdy=%0b busy=%0b left_reqs=%0d required 1 0 0",
                  cmd_rdy, busy, exp_addr_q.size());
      end
   endtask

   // scenarios
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      #1;
      tests_run += 3;
      if (cmd_rdy !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_rdy_busy: cmd_rdy=%0b busy=%0b required 1 0", cmd_rdy, busy);
      end
      if (resp_rd !== 5'd0) begin
         tests_failed++;
         $display("FAIL reset_resp_rd: resp_rd=%0d required=0", resp_rd);
      end
      if (misc_out !== 28'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: outputs=%h required=0", misc_out);
      end
      tick();
   endtask

   task automatic test_load_r();
      load_r(4'd5, 32'hA5A5_0005);
      #1;
      tests_run += 2;
      if (r_wen !== 1'b0 || resp_val !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL load_r_after: wen=%0b resp_val=%0b busy=%0b required 0 0 0", r_wen, resp_val, busy);
      end
      if (rf[5] !== 32'hA5A5_0005) begin
         tests_failed++;
         $display("FAIL load_r_data: R5=%h required=a5a50005", rf[5]);
      end
      tick();
   endtask

   task automatic test_drop();
      load_r(4'd1, 32'h0000_1111);
      cmd_val        = 1'b1;
      cmd_inst_funct = 7'h41;
      cmd_data       = 32'hDEAD_BEEF;
      #1;
      tests_run++;
      if (r_wen !== 1'b0 || cmd_rdy !== 1'b1) begin
         tests_failed++;
         $display("FAIL drop_accept: wen=%0b cmd_rdy=%0b required 0 1", r_wen, cmd_rdy);
      end
      tick();
      cmd_val = 1'b0;
      #1;
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL drop_busy: busy=%0b required=0", busy);
      end
      tick();
      tests_run++;
      if (rf[1] !== 32'h0000_1111) begin
         tests_failed++;
         $display("FAIL drop_no_write: R1=%h required=00001111", rf[1]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [4];
      int          c0;
      for (int i = 0; i < 4; i++) vals[i] = $urandom();
      c0 = cyc;
      for (int i = 0; i < 4; i++) load_r(4'(8 + i), vals[i]);
      tests_run++;
      if (cyc - c0 != 4) begin
         tests_failed++;
         $display("FAIL b2b_rate: cycles=%0d required=4", cyc - c0);
      end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (rf[8 + i] !== vals[i]) begin
            tests_failed++;
            $display("FAIL b2b_data: R%0d=%h required=%h", 8 + i, rf[8 + i], vals[i]);
         end
      end
   endtask

   task automatic test_dot_basic();
      mem[32] = 32'd1;  mem[33] = 32'd2;           mem[34] = 32'd3;
      mem[64] = 32'd4;  mem[65] = 32'hFFFF_FFFB;   mem[66] = 32'd6;
      run_dot(3, 32'h100, 32'h200, 32'h0, 5'd17, 0, 0);
      tests_run++;
      if (rf[4] !== 32'd12) begin
         tests_failed++;
         $display("FAIL dot_basic_r4: R4=%0d required=12", rf[4]);
      end
   endtask

   task automatic test_dot_relu();
      mem[40] = 32'd1;
      mem[72] = 32'hFFFF_FFF9;
      run_dot(1, 32'h140, 32'h240, 32'h0, 5'd3, 0, 0);
      run_dot(0, 32'h140, 32'h240, 32'hFFFF_FFFD, 5'd30, 0, 0);
   endtask

   task automatic test_stalls();
      mem[48] = 32'd5;  mem[49] = 32'd7;
      mem[80] = 32'd3;  mem[81] = 32'hFFFF_FFFE;
      req_block_left = 4;
      resp_extra     = 3;
      resp_rdy_block = 2;
      run_dot(2, 32'h180, 32'h280, 32'h0, 5'd21, 7, 9);
   endtask

   task automatic test_reset_mid_dot();
      bit found;
      load_r(4'd0, 32'h100);
      load_r(4'd1, 32'h200);
      load_r(4'd2, {16'd2, 16'h0});
      load_r(4'd3, 32'h0);
      load_r(4'd4, 32'h0);
      exp_addr_q.push_back(32'h100);
      exp_addr_q.push_back(32'h200);
      start_dot(5'd9);
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         if (state_dbg == 5'(ST_WTB)) found = 1;
         else tick();
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL reach_wtb: state=%0d required=%0d", state_dbg, ST_WTB);
      end
      reset_n = 1'b0;
      tick();
      #1;
      tests_run += 2;
      if (state_dbg !== 5'(ST_IDLE) || busy !== 1'b0 || resp_rd !== 5'd0) begin
         tests_failed++;
         $display("FAIL midreset_state: state=%0d busy=%0b resp_rd=%0d required IDLE 0 0",
                  state_dbg, busy, resp_rd);
      end
      if (misc_out !== 28'h0 || exp_addr_q.size() != 0) begin
         tests_failed++;
         $display("FAIL midreset_outputs: outputs=%h left_reqs=%0d required 0 0",
                  misc_out, exp_addr_q.size());
      end
      reset_n = 1'b1;
      tick();
      run_dot(2, 32'h180, 32'h280, 32'h0, 5'd12, 0, 0);
   endtask

   initial begin
      reset_n        = 1'b0;
      cmd_val        = 1'b0;
      cmd_inst_funct = 7'h0;
      cmd_inst_rd    = 5'd0;
      cmd_data       = 32'h0;
      mem_req_rdy    = 1'b1;
      mem_resp_val   = 1'b0;
      mem_resp_data  = 32'h0;
      resp_rdy       = 1'b1;
      a_eq_b         = 1'b0;
      a_reg          = 32'h0;
      b_reg          = 32'h0;
      for (int i = 0; i < 16; i++) rf[i] = 32'h0;
      for (int i = 0; i < 128; i++) mem[i] = 32'($urandom_range(0, 255));
      @(negedge clk);

      test_reset();
      test_load_r();
      test_drop();
      test_back_to_back();
      test_dot_basic();
      test_dot_relu();
      test_stalls();
      test_reset_mid_dot();

      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/serial_matmul_ctrl.md
# serial_matmul_ctrl

Control unit for the serial matmul datapath. It accepts processor commands over a val/rdy interface and sequences the shared R register file, A/B registers, adder, multiplier and ReLU, all of which sit on a tri-stated write bus. It also drives the single memory request/response port to compute a ReLU'd dot product, and returns a completion response to the processor. The unit sits between the accelerator command/response ports and `serial_matmul_dpath`.

## Interface
- `R_ADDR`, default 4: R register-file address width; 16 entries.
- `clk` in 1: clock.
- `reset_n` in 1: synchronous, active-low reset.
- `cmd_val` / `cmd_rdy`, in/out, 1 each: command handshake.
- `cmd_inst_funct` in 7: command opcode.
- `cmd_inst_rd` in 5: processor destination register, latched for the response.
- `mem_req_val` / `mem_req_rdy`, out/in, 1 each: memory request; load only.
- `mem_req_rw` out 1: tied 0.
- `mem_resp_val` / `mem_resp_rdy`, in/out, 1 each: memory response.
- `resp_val` / `resp_rdy`, out/in, 1 each: processor response.
- `resp_rd` out 5: latched `cmd_inst_rd`.
- `src_bus_en`, `resp_bus_en`, `add_bus_en`, `mul_bus_en`, `relu_bus_en`, `sws_bus_en`: out, 1 each, bus driver enables.
- `r_wen` out 1; `r_waddr`, `r_raddr0`, `r_raddr1` out `R_ADDR` each: R register-file control.
- `a_en`, `b_en` out 1 each: A/B register load enables.
- `add_sel` out 2: adder in0 select; 0 = A, 1 = +1, 2 = +2, 3 = +8.
- `comp_sel` out 1: comparator select; always 0, which compares N (A[31:16]) against B[15:0].
- `a_eq_b` in 1: comparator status.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- Fixed register map: R0 = A pointer, R1 = B pointer, R2 = {N[31:16], M[15:0]}, R3 = j, R4 = accumulator, R5 = a temp, R6 = b temp, R7 = product.
- Command decode:
  - `funct[6]=0` is LOAD_R. In IDLE, on `cmd_val&cmd_rdy`: assert `src_bus_en`, `r_wen`, and `r_waddr=funct[3:0]` in the same cycle. No response is sent.
  - `funct=7'h40` is DOT. Latch rd and go to CHK. Software must preload R3=0 and R4=0.
  - Any other funct with `funct[6]=1` is accepted and dropped: no write, no response.
- DOT states and transitions:
  - CHK: `raddr0=R2`, `raddr1=R3`, `a_en`, `b_en` → CMP.
  - CMP: if `a_eq_b` → RLD, else → REQA.
  - REQA: `mem_req_val`, `raddr0=R0`. Stay until `mem_req_rdy`, then → WTA.
  - WTA: `mem_resp_rdy=1`. On `mem_resp_val`: `resp_bus_en`, `r_wen`, `waddr=R5` → REQB.
  - REQB / WTB: same as REQA / WTA, using R1 and R6.
  - MLD (R5→A, R6→B) → MUL: `mul_bus_en`, write R7.
  - ALD (R4→A, R7→B) → ACC: `add_sel=0`, `add_bus_en`, write R4.
  - PALD (R0→B) → PA: `add_sel=3`, write R0.
  - PBLD (R1→B) → PB: `add_sel=3`, write R1.
  - JLD (R3→B) → J: `add_sel=1`, write R3. → CHK.
  - RLD (R4→B) → RELU: `relu_bus_en`, write R4 → RESP.
  - RESP: `resp_val` held until `resp_rdy`, then → IDLE.
- Invariants:
  - At most one `*_bus_en` is high in any cycle, and only in a cycle with `r_wen=1`.
  - `sws_bus_en` is always 0.
- `cmd_rdy=1` only in IDLE.
- All outputs are Moore (decoded from state), except the LOAD_R write strobes and the WTA/WTB write strobes, which are qualified by the handshake inputs.
- Arithmetic wraps modulo 2^`R_BITS`; the controller itself does no arithmetic.

## Timing
- Reset (`reset_n=0` at a posedge): state → IDLE. `busy=0`, `cmd_rdy=1` after release; every other output is 0, and `resp_rd` is 0.
- Reset mid-DOT: abort immediately. The memory system is reset with this unit, so no stale response arrives.
- LOAD_R takes 1 cycle. Back-to-back LOAD_Rs sustain one per cycle.
- DOT with zero-wait memory (`mem_req_rdy=1`, response one cycle after request): the acceptance cycle is 0, and `resp_val` first rises in cycle 16N+5.
- N=0 gives cycle 5, with R4 ← ReLU(R4).
- Each stall cycle on `mem_req_rdy`, `mem_resp_val` or `resp_rdy` adds exactly one cycle.
- `mem_req_val`, once raised, stays high until accepted. The request address (`raddr0`) is stable throughout.
- `mem_resp_val` outside WTA/WTB is ignored (`mem_resp_rdy=0` there).

## Structure
- Package `sm_ctrl_pkg` holds:
  - state enum;
  - funct constants `SM_FUNCT_DOT=7'h40` and the LOAD_R mask;
  - register-index constants R0–R7;
  - `add_sel` codes.
- Single module, no sub-modules: a registered state plus a combinational output decoder.

## Test plan
- Reset: hold `reset_n=0` for 3 cycles → all outputs 0 except `cmd_rdy=1` after release; `busy=0`.
- LOAD_R: funct=7'h05, `cmd_val` for 1 cycle → same cycle `src_bus_en=1`, `r_wen=1`, `r_waddr=5`; no `resp_val`.
- DOT with A=[1,2,3] and B=[4,-5,6] (N=3, zero-wait memory): six requests at R0/R1 addresses spaced by 8 → R4=12 after ReLU; `resp_val` at cycle 53; `resp_rd` equals the latched rd.
- DOT with A=[1], B=[-7] → R4=0 (ReLU clamps); N=0 → `resp_val` at cycle 5.
- Stalls: `mem_req_rdy` low for 4 cycles, response delayed 3 cycles, `resp_rdy` low for 2 cycles → `mem_req_val` and its address held steady; total latency grows by exactly the stall count.
- Reset asserted in WTB → next cycle IDLE with all outputs cleared; a new DOT then completes correctly.
